// File: rtl/interrupt_controller_pkg.sv
// interrupt_controller_pkg: shared FSM state type and cause-word constants
package interrupt_controller_pkg;
   typedef enum logic [1:0] {SCAN, REQUEST, SERVICE} state_t;
   localparam int MAX_DEV = 31;
   localparam int DEV_W = 5;
   function automatic int cause_flag_bit(input int width);
      return width - 1;
   endfunction
endpackage

// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: device/CPU side signals of the interrupt controller
interface interrupt_controller_if
   import interrupt_controller_pkg::*;
#(
   parameter int NUM_DEV = 31,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_DEV-1:0] irq;
   logic int_permit;
   logic int_ack;
   logic eoi;
   logic [DEV_W-1:0] int_device;
   logic int_req;
   logic [DATA_WIDTH-1:0] int_cause;
   logic [NUM_DEV-1:0] pending;
   logic busy;
   modport master (output irq, int_permit, int_ack, eoi,
                   input int_device, int_req, int_cause, pending, busy);
   modport slave (input irq, int_permit, int_ack, eoi,
                  output int_device, int_req, int_cause, pending, busy);
endinterface

// File: rtl/interrupt_controller_irq_sync_edge.sv
// irq_sync_edge: 2-flop synchronizer plus rising-edge detector per request line
module irq_sync_edge #(
   parameter int WIDTH = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] rise
);
   logic [WIDTH-1:0] s1, s2, prev, armed;
   logic [1:0] primed;
   // a line must be seen low after reset before it may report an edge
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
         prev <= '0;
         armed <= '0;
         primed <= '0;
      end else begin
         s1 <= d;
         s2 <= s1;
         prev <= s2;
         primed <= {primed[0], 1'b1};
         armed <= armed | ({WIDTH{primed[1]}} & ~s2);
      end
   assign rise = s2 & ~prev & armed;
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: round-robin scanner that forwards pending device interrupts to the CPU
module interrupt_controller
   import interrupt_controller_pkg::*;
#(
   parameter int NUM_DEV = 31,
   parameter int DATA_WIDTH = 32
) (
   input logic clk,
   input logic rst,
   interrupt_controller_if.slave bus
);
   localparam logic [DEV_W-1:0] LAST = DEV_W'(NUM_DEV - 1);
   localparam int FLAG = cause_flag_bit(DATA_WIDTH);
   state_t state, state_n;
   logic [DEV_W-1:0] ptr, ptr_n, ptr_inc;
   logic [NUM_DEV-1:0] pending, rise, clr;
   logic int_req, busy, req_n, busy_n;
   irq_sync_edge #(.WIDTH(NUM_DEV)) u_sync (.clk(clk), .rst(rst), .d(bus.irq), .rise(rise));
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= SCAN;
         ptr <= '0;
         pending <= '0;
         int_req <= 1'b0;
         busy <= 1'b0;
      end else begin
         state <= state_n;
         ptr <= ptr_n;
         pending <= (pending & ~clr) | rise;
         int_req <= req_n;
         busy <= busy_n;
      end
   assign ptr_inc = (ptr == LAST) ? '0 : ptr + 1'b1;
   always_comb begin
      state_n = state;
      ptr_n = ptr;
      case (state)
         SCAN:
            if (pending[ptr] && bus.int_permit) state_n = REQUEST;
            else ptr_n = ptr_inc;
         REQUEST:
            if (bus.int_ack) state_n = SERVICE;
            else if (!bus.int_permit) begin
               state_n = SCAN;
               ptr_n = ptr_inc;
            end
         SERVICE:
            if (bus.eoi) begin
               state_n = SCAN;
               ptr_n = ptr_inc;
            end
         default: state_n = SCAN;
      endcase
   end
   // outputs are decoded from the next state so they leave the block registered
   always_comb begin
      req_n = state_n == REQUEST;
      busy_n = state_n == SERVICE;
      clr = (state == REQUEST && bus.int_ack) ? NUM_DEV'(1) << ptr : '0;
   end
   always_comb begin
      bus.int_cause = '0;
      bus.int_cause[FLAG] = 1'b1;
      bus.int_cause[DEV_W-1:0] = ptr;
   end
   assign bus.int_device = ptr;
   assign bus.int_req = int_req;
   assign bus.busy = busy;
   assign bus.pending = pending;
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: scoreboard bench for the interrupt controller
module tb_interrupt_controller;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [31:0] permit_mask = '1;
   int vectors = 0;
   int miscompares = 0;
   int exp_q[$];
   interrupt_controller_if #(.NUM_DEV(31), .DATA_WIDTH(32)) bus ();
   interrupt_controller #(.NUM_DEV(31), .DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   assign bus.int_permit = permit_mask[bus.int_device];
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (bus.int_req) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("req_timeout", 32'd0, 32'd1);
   endtask

   task automatic fire(input int idx);
      bus.irq[idx] = 1'b1;
      repeat (4) @(negedge clk);
      bus.irq[idx] = 1'b0;
   endtask

   task automatic eoi_pulse(input int nxt);
      bus.eoi = 1'b1;
      @(negedge clk);
      bus.eoi = 1'b0;
      chk("busy_eoi", 32'(bus.busy), 32'd0);
      chk("ptr_eoi", 32'(bus.int_device), nxt);
   endtask

   task automatic serve(input bit chk_clr, input bit do_eoi);
      bit ok;
      int dev;
      dev = exp_q.pop_front();
      wait_req(ok);
      chk("int_device", 32'(bus.int_device), dev);
      chk("int_cause", bus.int_cause, 32'h8000_0000 | dev);
      bus.int_ack = 1'b1;
      @(negedge clk);
      bus.int_ack = 1'b0;
      chk("busy_ack", 32'(bus.busy), 32'd1);
      chk("req_ack", 32'(bus.int_req), 32'd0);
      if (chk_clr) chk("pend_clr", 32'(bus.pending[dev]), 32'd0);
      if (do_eoi) eoi_pulse((dev + 1) % 31);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit ok;
      bus.irq = '0;
      bus.int_ack = 1'b0;
      bus.eoi = 1'b0;
      #1;
      chk("rst_pending", 32'(bus.pending), 32'd0);
      chk("rst_req", 32'(bus.int_req), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_device", 32'(bus.int_device), 32'd0);
      chk("rst_cause", bus.int_cause, 32'h8000_0000);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      // single request, three-edge set latency, level-high not re-pending
      bus.irq[3] = 1'b1;
      @(negedge clk);
      chk("edge1_p3", 32'(bus.pending[3]), 32'd0);
      @(negedge clk);
      chk("edge2_p3", 32'(bus.pending[3]), 32'd0);
      @(negedge clk);
      chk("edge3_p3", 32'(bus.pending[3]), 32'd1);
      exp_q.push_back(3);
      serve(1'b1, 1'b1);
      chk("level_no_reset", 32'(bus.pending[3]), 32'd0);
      bus.irq[3] = 1'b0;
      bus.int_ack = 1'b1;
      @(negedge clk);
      bus.int_ack = 1'b0;
      chk("stray_ack", 32'(bus.busy), 32'd0);
      // masked device is skipped until permitted
      permit_mask[2] = 1'b0;
      fire(2);
      exp_q.push_back(5);
      fire(5);
      serve(1'b1, 1'b1);
      chk("masked_kept", 32'(bus.pending[2]), 32'd1);
      permit_mask[2] = 1'b1;
      exp_q.push_back(2);
      serve(1'b1, 1'b1);
      // round robin: re-pended device 1 waits behind device 2
      exp_q.push_back(1);
      fire(1);
      serve(1'b1, 1'b0);
      fire(2);
      fire(1);
      chk("rr_pending", 32'(bus.pending[2:1]), 32'd3);
      eoi_pulse(2);
      exp_q.push_back(2);
      exp_q.push_back(1);
      serve(1'b1, 1'b1);
      serve(1'b1, 1'b1);
      // cancel by dropping permit in REQUEST
      fire(7);
      wait_req(ok);
      chk("cancel_dev", 32'(bus.int_device), 32'd7);
      permit_mask[7] = 1'b0;
      @(negedge clk);
      chk("cancel_req", 32'(bus.int_req), 32'd0);
      chk("cancel_pend", 32'(bus.pending[7]), 32'd1);
      chk("cancel_ptr", 32'(bus.int_device), 32'd8);
      permit_mask[7] = 1'b1;
      exp_q.push_back(7);
      serve(1'b1, 1'b1);
      // edge and ack on the same bit in one cycle: set wins
      fire(0);
      wait_req(ok);
      chk("coll_dev", 32'(bus.int_device), 32'd0);
      bus.irq[0] = 1'b1;
      repeat (2) @(negedge clk);
      bus.int_ack = 1'b1;
      @(negedge clk);
      bus.int_ack = 1'b0;
      chk("coll_pend", 32'(bus.pending[0]), 32'd1);
      chk("coll_busy", 32'(bus.busy), 32'd1);
      eoi_pulse(1);
      exp_q.push_back(0);
      serve(1'b1, 1'b1);
      bus.irq[0] = 1'b0;
      // scan pointer wraps from last device to 0
      ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (bus.int_device == 5'd30) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("wrap_timeout", 32'd0, 32'd1);
      @(negedge clk);
      chk("scan_wrap", 32'(bus.int_device), 32'd0);
      exp_q.push_back(30);
      fire(30);
      serve(1'b1, 1'b1);
      // asynchronous reset while in SERVICE
      exp_q.push_back(4);
      fire(4);
      serve(1'b1, 1'b0);
      bus.irq[9] = 1'b1;
      repeat (4) @(negedge clk);
      chk("pre_rst_p9", 32'(bus.pending[9]), 32'd1);
      rst = 1'b1;
      #1;
      chk("arst_req", 32'(bus.int_req), 32'd0);
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_pending", 32'(bus.pending), 32'd0);
      chk("arst_device", 32'(bus.int_device), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("held_no_edge", 32'(bus.pending), 32'd0);
      chk("held_no_req", 32'(bus.int_req), 32'd0);
      bus.irq[9] = 1'b0;
      repeat (3) @(negedge clk);
      exp_q.push_back(9);
      fire(9);
      serve(1'b1, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
